uart_flow_tx: RTL and testbench

Buffered UART transmitter with hardware flow control. It sends 8N1 frames toward a peer receiver, and starts a new frame only while the peer's clear-to-send input permits. The input is a valid/ready byte stream into a small FIFO. The block is the host-side transmit end for the SoC UART receiver: it drives that receiver's serial input and honours its RTS (high = hold off).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_flow_tx.sv | 157 +++++++++++++++
 tb/tb_uart_flow_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the flow-controlled UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } uart_state_e;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty.
// Read data is combinational from the head entry.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/uart_flow_tx.sv
// Buffered 8N1 UART transmitter; a new frame starts only while the synchronized CTS is low.
// Frames always complete once started; GUARD idle clocks follow each stop bit.
module uart_flow_tx
    import uart_pkg::*;
#(
    parameter int DIV   = 1,
    parameter int DEPTH = 4,
    parameter int GUARD = 4,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ser_tx,
    input  logic          ser_cts,
    output logic          busy,
    output logic [LW-1:0] level
);

    localparam logic [15:0] BIT_LOAD = 16'(DIV - 1);
    localparam logic [15:0] GAP_LOAD = 16'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        cts_meta_q, cts_s_q;
    logic        pop, launch_ok, tick;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .din_i   (in_data),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Both stages reset to "not ready" so nothing launches until the peer is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_meta_q <= 1'b1;
            cts_s_q    <= 1'b1;
        end else begin
            cts_meta_q <= ser_cts;
            cts_s_q    <= cts_meta_q;
        end
    end

    assign tick = (timer_q == '0);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        launch_ok = 1'b0;
        case (state_q)
            IDLE: begin
                launch_ok = 1'b1;
                tx_d      = UART_LINE_IDLE;
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    timer_d   = BIT_LOAD;
                    bit_cnt_d = '0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d = BIT_LOAD;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = UART_LINE_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (GUARD == 0) begin
                        state_d   = IDLE;
                        launch_ok = 1'b1;
                    end else begin
                        state_d = GAP;
                        timer_d = GAP_LOAD;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d   = IDLE;
                    launch_ok = 1'b1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The start decision is taken on the same edge that ends stop/guard,
        // keeping back-to-back frames at exactly 10*DIV+GUARD clocks.
        if (launch_ok && !fifo_empty && !cts_s_q) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            tx_d    = 1'b0;
            state_d = START;
            timer_d = BIT_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= UART_LINE_IDLE;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign ser_tx   = tx_q;
    assign in_ready = !fifo_full;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_flow_tx.sv
// Directed bench for uart_flow_tx: one instance at DIV=4/GUARD=4, one at DIV=1/GUARD=0.
module tb_uart_flow_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_cts;
    logic [7:0] in_data0, in_data1;
    logic       in_valid0, in_valid1;
    logic       in_ready0, in_ready1;
    logic       tx0, tx1;
    logic       busy0, busy1;
    logic [2:0] level0, level1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_flow_tx #(.DIV(4), .DEPTH(4), .GUARD(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .ser_tx(tx0), .ser_cts(ser_cts),
        .busy(busy0), .level(level0)
    );

    uart_flow_tx #(.DIV(1), .DEPTH(4), .GUARD(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .ser_tx(tx1), .ser_cts(ser_cts),
        .busy(busy1), .level(level1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel != 0) ? tx1 : tx0;
    endfunction

    // Polls on falling edges until the line is low; a timeout is a failed check.
    task automatic wait_fall(input int sel, input int budget, input string tag, output int at);
        int n;
        n = 0;
        while (get_tx(sel) !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        chk(tag, 32'(get_tx(sel)), 32'd0);
    endtask

    // Starts on the first low negedge; checks every clock of the 10-bit frame.
    task automatic check_frame(input int sel, input logic [7:0] b, input int div,
                               input int raise_bit, input string tag);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < div; k++) begin
                if (i == raise_bit && k == 0) ser_cts = 1'b1;
                chk($sformatf("%s_bit%0d", tag, i), 32'(get_tx(sel)), 32'(f[i]));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int c0, s0, s1, s2, cd;
        rst = 1'b1; ser_cts = 1'b1;
        in_data0 = 8'h00; in_valid0 = 1'b0;
        in_data1 = 8'h00; in_valid1 = 1'b0;
        #1;
        chk("rst_tx", 32'(tx0), 32'd1);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_level", 32'(level0), 32'd0);
        @(negedge clk); rst = 1'b0; ser_cts = 1'b0;
        repeat (3) @(negedge clk);

        // Single frame 0xA5, start latency and busy release after guard
        in_data0 = 8'hA5; in_valid0 = 1'b1;
        @(negedge clk); in_valid0 = 1'b0; c0 = cyc;
        chk("t1_level_after_push", 32'(level0), 32'd1);
        @(negedge clk);
        wait_fall(0, 5, "t1_fall", s0);
        chk("t1_start_latency", 32'(s0 - c0), 32'd1);
        check_frame(0, 8'hA5, 4, -1, "t1_a5");
        for (int i = 0; i < 4; i++) begin
            chk("t1_guard_busy", 32'(busy0), 32'd1);
            chk("t1_guard_tx", 32'(tx0), 32'd1);
            @(negedge clk);
        end
        chk("t1_busy_drop", 32'(busy0), 32'd0);

        // Held off by CTS, then three frames 44 clocks apart
        ser_cts = 1'b1;
        repeat (3) @(negedge clk);
        in_data0 = 8'h01; in_valid0 = 1'b1;
        @(negedge clk); in_data0 = 8'h02;
        @(negedge clk); in_data0 = 8'h03;
        @(negedge clk); in_valid0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_level_held", 32'(level0), 32'd3);
        chk("t2_tx_held", 32'(tx0), 32'd1);
        ser_cts = 1'b0;
        wait_fall(0, 10, "t2_fall0", s0);
        check_frame(0, 8'h01, 4, -1, "t2_f01");
        wait_fall(0, 10, "t2_fall1", s1);
        chk("t2_spacing01", 32'(s1 - s0), 32'd44);
        check_frame(0, 8'h02, 4, -1, "t2_f02");
        wait_fall(0, 10, "t2_fall2", s2);
        chk("t2_spacing12", 32'(s2 - s1), 32'd44);
        check_frame(0, 8'h03, 4, -1, "t2_f03");
        repeat (6) @(negedge clk);

        // CTS rises during data bit 3; frame completes, next waits for CTS
        in_data0 = 8'h55; in_valid0 = 1'b1;
        @(negedge clk); in_data0 = 8'h66;
        @(negedge clk); in_valid0 = 1'b0;
        wait_fall(0, 5, "t3_fall55", s0);
        check_frame(0, 8'h55, 4, 4, "t3_f55");
        repeat (12) begin
            chk("t3_hold_tx", 32'(tx0), 32'd1);
            @(negedge clk);
        end
        chk("t3_hold_level", 32'(level0), 32'd1);
        ser_cts = 1'b0; cd = cyc;
        @(negedge clk);
        wait_fall(0, 10, "t3_fall66", s1);
        chk("t3_cts_to_start", 32'(s1 - cd), 32'd3);
        check_frame(0, 8'h66, 4, -1, "t3_f66");
        repeat (6) @(negedge clk);

        // Fill to DEPTH with CTS high; 5th byte held until the first pop
        ser_cts = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_data0 = 8'(8'h11 + i); in_valid0 = 1'b1;
            @(negedge clk);
        end
        in_data0 = 8'h15;
        chk("t4_full_ready", 32'(in_ready0), 32'd0);
        chk("t4_full_level", 32'(level0), 32'd4);
        repeat (3) @(negedge clk);
        chk("t4_still_full", 32'(level0), 32'd4);
        ser_cts = 1'b0;
        wait_fall(0, 10, "t4_fall11", s0);
        chk("t4_ready_after_pop", 32'(in_ready0), 32'd1);
        chk("t4_level_after_pop", 32'(level0), 32'd3);
        fork
            check_frame(0, 8'h11, 4, -1, "t4_f11");
            begin
                @(negedge clk);
                in_valid0 = 1'b0;
                chk("t4_level_refill", 32'(level0), 32'd4);
            end
        join
        for (int i = 1; i < 5; i++) begin
            wait_fall(0, 10, "t4_fall", s1);
            chk("t4_spacing", 32'(s1 - s0), 32'd44);
            s0 = s1;
            check_frame(0, 8'(8'h11 + i), 4, -1, $sformatf("t4_f%0d", i));
        end
        repeat (6) @(negedge clk);

        // Asynchronous reset mid data bit
        in_data0 = 8'h3C; in_valid0 = 1'b1;
        @(negedge clk); in_data0 = 8'h99;
        @(negedge clk); in_valid0 = 1'b0;
        wait_fall(0, 5, "t5_fall3c", s0);
        repeat (10) @(negedge clk);
        chk("t5_pre_level", 32'(level0), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_tx", 32'(tx0), 32'd1);
        chk("t5_rst_level", 32'(level0), 32'd0);
        chk("t5_rst_busy", 32'(busy0), 32'd0);
        chk("t5_rst_ready", 32'(in_ready0), 32'd1);
        @(negedge clk); rst = 1'b0;
        in_data0 = 8'h5A; in_valid0 = 1'b1;
        @(negedge clk); in_valid0 = 1'b0;
        wait_fall(0, 10, "t5_fall5a", s0);
        check_frame(0, 8'h5A, 4, -1, "t5_f5a");
        repeat (6) @(negedge clk);
        chk("t5_idle_after", 32'(busy0), 32'd0);

        // DIV=1, GUARD=0: back-to-back 10-clock frames
        in_data1 = 8'h00; in_valid1 = 1'b1;
        @(negedge clk); in_data1 = 8'hFF;
        @(negedge clk); in_valid1 = 1'b0;
        wait_fall(1, 5, "t6_fall00", s0);
        check_frame(1, 8'h00, 1, -1, "t6_f00");
        check_frame(1, 8'hFF, 1, -1, "t6_fff");
        chk("t6_busy_end", 32'(busy1), 32'd0);
        chk("t6_tx_end", 32'(tx1), 32'd1);
        chk("t6_level_end", 32'(level1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
